// File: rtl/rf_video_pkg.sv
// Shared constants and types for the video frame signature monitor.
// Timing fields are sized for the widest supported counter; narrower counters are zero-extended.
package rf_video_pkg;

    localparam logic [31:0] CRC32_POLY_R = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_XOROUT = 32'hFFFF_FFFF;

    localparam int TIMING_W = 16;

    typedef enum logic {
        SYNC_ACTIVE_LOW  = 1'b0,
        SYNC_ACTIVE_HIGH = 1'b1
    } sync_pol_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC_WAIT,
        ST_MEASURE
    } mon_state_e;

    typedef struct packed {
        logic [TIMING_W-1:0] htotal;
        logic [TIMING_W-1:0] hactive;
        logic [TIMING_W-1:0] vtotal;
        logic [TIMING_W-1:0] vactive;
    } video_timing_t;

    function automatic logic [31:0] crc32_finalize(input logic [31:0] acc);
        return acc ^ CRC32_XOROUT;
    endfunction

endpackage

// File: rtl/rf_crc32_update.sv
// Combinational reflected CRC-32 step over DATA_W bits.
// Bits are consumed in index order, so byte 0 goes first and each byte LSB first.
module rf_crc32_update
    import rf_video_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [31:0]       crc_in,
    input  logic [DATA_W-1:0] data,
    output logic [31:0]       crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 0; i < DATA_W; i++) begin
            c = (c >> 1) ^ (((c[0] ^ data[i]) == 1'b1) ? CRC32_POLY_R : 32'h0);
        end
        crc_out = c;
    end

endmodule

// File: rtl/rf_video_frame_signature.sv
// Passive raster monitor: measures per-frame timing and a CRC-32 over active pixels,
// and flags frames whose signature differs from the expected value.
module rf_video_frame_signature
    import rf_video_pkg::*;
#(
    parameter int   PIX_W     = 32,
    parameter int   CTR_W     = 12,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic             dot_clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [PIX_W-1:0] rgb_i,
    input  logic             hsync_i,
    input  logic             vsync_i,
    input  logic             blank_i,
    input  logic [31:0]      exp_crc_i,
    input  logic             exp_valid_i,
    input  logic             clr_i,
    output logic [31:0]      crc_o,
    output logic [CTR_W-1:0] htotal_o,
    output logic [CTR_W-1:0] hactive_o,
    output logic [CTR_W-1:0] vtotal_o,
    output logic [CTR_W-1:0] vactive_o,
    output logic [15:0]      frame_cnt_o,
    output logic             meas_valid_o,
    output logic             stable_o,
    output logic             mismatch_o,
    output logic             irq_o
);

    localparam sync_pol_e H_ACT = sync_pol_e'(HSYNC_POL);
    localparam sync_pol_e V_ACT = sync_pol_e'(VSYNC_POL);

    mon_state_e state;

    logic             hs_r, hs_q, vs_r, vs_q, blank_r;
    logic [PIX_W-1:0] rgb_r;

    logic [CTR_W-1:0] hcnt, acnt, lines, lines_act;
    logic [CTR_W-1:0] htotal_acc, hactive_acc;
    logic [31:0]      crc_acc;

    logic             h_edge, v_edge, active, acnt_closed;
    logic [CTR_W-1:0] htotal_new, hactive_new, vtotal_new, vactive_new;
    logic [31:0]      crc_src, crc_upd, crc_final;
    video_timing_t    new_timing, cur_timing;

    function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] v);
        return (&v) ? v : v + CTR_W'(1);
    endfunction

    // Input stage plus one extra sync delay for edge detection; syncs idle at their inactive level.
    always_ff @(posedge dot_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hs_r    <= ~H_ACT;
            hs_q    <= ~H_ACT;
            vs_r    <= ~V_ACT;
            vs_q    <= ~V_ACT;
            blank_r <= 1'b1;
            rgb_r   <= '0;
        end else begin
            hs_r    <= hsync_i;
            hs_q    <= hs_r;
            vs_r    <= vsync_i;
            vs_q    <= vs_r;
            blank_r <= blank_i;
            rgb_r   <= rgb_i;
        end
    end

    // A v-edge restarts the CRC from the init value so a pixel on that cycle opens the new frame.
    always_comb begin
        h_edge      = (hs_r == H_ACT) && (hs_q != H_ACT);
        v_edge      = (vs_r == V_ACT) && (vs_q != V_ACT);
        active      = ~blank_r;
        acnt_closed = h_edge && (acnt != '0);
        crc_src     = v_edge ? CRC32_INIT : crc_acc;
        crc_final   = crc32_finalize(crc_acc);

        htotal_new  = h_edge ? hcnt : htotal_acc;
        hactive_new = acnt_closed ? acnt : hactive_acc;
        vtotal_new  = h_edge ? sat_inc(lines) : lines;
        vactive_new = acnt_closed ? sat_inc(lines_act) : lines_act;

        new_timing.htotal  = TIMING_W'(htotal_new);
        new_timing.hactive = TIMING_W'(hactive_new);
        new_timing.vtotal  = TIMING_W'(vtotal_new);
        new_timing.vactive = TIMING_W'(vactive_new);
        cur_timing.htotal  = TIMING_W'(htotal_o);
        cur_timing.hactive = TIMING_W'(hactive_o);
        cur_timing.vtotal  = TIMING_W'(vtotal_o);
        cur_timing.vactive = TIMING_W'(vactive_o);
    end

    rf_crc32_update #(
        .DATA_W (PIX_W)
    ) u_crc (
        .crc_in  (crc_src),
        .data    (rgb_r),
        .crc_out (crc_upd)
    );

    // Monitor FSM with accumulators and registered results; a set of mismatch beats a clear.
    always_ff @(posedge dot_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= ST_IDLE;
            hcnt         <= '0;
            acnt         <= '0;
            lines        <= '0;
            lines_act    <= '0;
            htotal_acc   <= '0;
            hactive_acc  <= '0;
            crc_acc      <= CRC32_INIT;
            crc_o        <= '0;
            htotal_o     <= '0;
            hactive_o    <= '0;
            vtotal_o     <= '0;
            vactive_o    <= '0;
            frame_cnt_o  <= '0;
            meas_valid_o <= 1'b0;
            stable_o     <= 1'b0;
            mismatch_o   <= 1'b0;
        end else begin
            meas_valid_o <= 1'b0;
            if (clr_i) begin
                mismatch_o <= 1'b0;
            end

            if (!en_i || state == ST_IDLE) begin
                state       <= en_i ? ST_SYNC_WAIT : ST_IDLE;
                hcnt        <= '0;
                acnt        <= '0;
                lines       <= '0;
                lines_act   <= '0;
                htotal_acc  <= '0;
                hactive_acc <= '0;
                crc_acc     <= CRC32_INIT;
                stable_o    <= 1'b0;
            end else if (state == ST_MEASURE || v_edge) begin
                state <= ST_MEASURE;
                hcnt  <= h_edge ? CTR_W'(1) : sat_inc(hcnt);

                if (v_edge) begin
                    if (state == ST_MEASURE) begin
                        htotal_o     <= htotal_new;
                        hactive_o    <= hactive_new;
                        vtotal_o     <= vtotal_new;
                        vactive_o    <= vactive_new;
                        crc_o        <= crc_final;
                        frame_cnt_o  <= frame_cnt_o + 16'd1;
                        meas_valid_o <= 1'b1;
                        stable_o     <= (new_timing == cur_timing);
                        if (exp_valid_i && (crc_final != exp_crc_i)) begin
                            mismatch_o <= 1'b1;
                        end
                    end
                    htotal_acc  <= '0;
                    hactive_acc <= '0;
                    lines       <= '0;
                    lines_act   <= '0;
                    acnt        <= active ? CTR_W'(1) : '0;
                    crc_acc     <= active ? crc_upd : CRC32_INIT;
                end else begin
                    if (h_edge) begin
                        htotal_acc <= hcnt;
                        lines      <= sat_inc(lines);
                    end
                    if (acnt_closed) begin
                        hactive_acc <= acnt;
                        lines_act   <= sat_inc(lines_act);
                    end
                    if (h_edge) begin
                        acnt <= active ? CTR_W'(1) : '0;
                    end else if (active) begin
                        acnt <= sat_inc(acnt);
                    end
                    if (active) begin
                        crc_acc <= crc_upd;
                    end
                end
            end
        end
    end

    assign irq_o = mismatch_o;

endmodule

// File: tb/tb_rf_video_frame_signature.sv
// Directed-sequence bench for rf_video_frame_signature with random pixel data
// checked against a raster/CRC reference model kept in the bench.
module tb_rf_video_frame_signature;

    logic        dot_clk     = 1'b0;
    logic        rst_ni      = 1'b1;
    logic        en_i        = 1'b0;
    logic [31:0] rgb_i       = '0;
    logic        hsync_i     = 1'b1;
    logic        vsync_i     = 1'b1;
    logic        blank_i     = 1'b1;
    logic [31:0] exp_crc_i   = '0;
    logic        exp_valid_i = 1'b0;
    logic        clr_i       = 1'b0;

    logic [31:0] crc_o;
    logic [11:0] htotal_o, hactive_o, vtotal_o, vactive_o;
    logic [15:0] frame_cnt_o;
    logic        meas_valid_o, stable_o, mismatch_o, irq_o;

    int checks = 0;
    int errors = 0;

    int          mh [0:31];
    int          mha[0:31];
    int          mv [0:31];
    int          mva[0:31];
    logic [31:0] mcrc[0:31];
    int          fidx = 0;

    int last_h = 0, last_ha = 0, last_v = 0, last_va = 0;
    int m_cnt = 0;
    bit m_mm = 1'b0;
    bit m_stable;

    int          pulses;
    logic [31:0] cap_crc;
    logic [11:0] cap_h, cap_ha, cap_v, cap_va;
    logic [15:0] cap_cnt;
    logic        cap_stable, cap_mm, cap_irq;

    rf_video_frame_signature dut (
        .dot_clk_i    (dot_clk),
        .rst_ni       (rst_ni),
        .en_i         (en_i),
        .rgb_i        (rgb_i),
        .hsync_i      (hsync_i),
        .vsync_i      (vsync_i),
        .blank_i      (blank_i),
        .exp_crc_i    (exp_crc_i),
        .exp_valid_i  (exp_valid_i),
        .clr_i        (clr_i),
        .crc_o        (crc_o),
        .htotal_o     (htotal_o),
        .hactive_o    (hactive_o),
        .vtotal_o     (vtotal_o),
        .vactive_o    (vactive_o),
        .frame_cnt_o  (frame_cnt_o),
        .meas_valid_o (meas_valid_o),
        .stable_o     (stable_o),
        .mismatch_o   (mismatch_o),
        .irq_o        (irq_o)
    );

    always #5 dot_clk = ~dot_clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Standard byte-wise reflected CRC-32 over the four bytes of a pixel, byte 0 first.
    function automatic logic [31:0] crc_add_pixel(input logic [31:0] c, input logic [31:0] pix);
        logic [31:0] r;
        r = c;
        for (int b = 0; b < 4; b++) begin
            r = r ^ {24'h0, pix[8*b +: 8]};
            for (int k = 0; k < 8; k++) begin
                r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
            end
        end
        return r;
    endfunction

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_crc"},        crc_o, 32'h0);
        checkOutput({tag, "_htotal"},     32'(htotal_o), 32'h0);
        checkOutput({tag, "_hactive"},    32'(hactive_o), 32'h0);
        checkOutput({tag, "_vtotal"},     32'(vtotal_o), 32'h0);
        checkOutput({tag, "_vactive"},    32'(vactive_o), 32'h0);
        checkOutput({tag, "_frame_cnt"},  32'(frame_cnt_o), 32'h0);
        checkOutput({tag, "_meas_valid"}, 32'(meas_valid_o), 32'h0);
        checkOutput({tag, "_stable"},     32'(stable_o), 32'h0);
        checkOutput({tag, "_mismatch"},   32'(mismatch_o), 32'h0);
        checkOutput({tag, "_irq"},        32'(irq_o), 32'h0);
    endtask

    // One full frame starting at its vsync/hsync edge; hsync on x=0..1, vsync on row 0,
    // active window at x=4.., rows 1... Records the frame's expected results in the model.
    task automatic applyStimulus(input int h, input int ha, input int v, input int va,
                                 input bit zero_pix, input int clr_cyc,
                                 input int en_off_cyc, input int rst_cyc);
        logic [31:0] crc;
        logic [31:0] pix;
        bit          act;
        int          i;
        crc    = 32'hFFFF_FFFF;
        pulses = 0;
        for (int y = 0; y < v; y++) begin
            for (int x = 0; x < h; x++) begin
                i = y * h + x;
                if (rst_cyc >= 0 && i == rst_cyc + 3) rst_ni = 1'b1;
                act     = (y >= 1) && (y < 1 + va) && (x >= 4) && (x < 4 + ha);
                pix     = zero_pix ? 32'h0 : $urandom;
                hsync_i = (x < 2) ? 1'b0 : 1'b1;
                vsync_i = (y == 0) ? 1'b0 : 1'b1;
                blank_i = ~act;
                rgb_i   = pix;
                if (act) crc = crc_add_pixel(crc, pix);
                clr_i = (i == clr_cyc);
                if (en_off_cyc >= 0) en_i = !(i >= en_off_cyc && i < en_off_cyc + 5);
                @(posedge dot_clk);
                #1;
                if (meas_valid_o) begin
                    pulses++;
                    cap_crc    = crc_o;
                    cap_h      = htotal_o;
                    cap_ha     = hactive_o;
                    cap_v      = vtotal_o;
                    cap_va     = vactive_o;
                    cap_cnt    = frame_cnt_o;
                    cap_stable = stable_o;
                    cap_mm     = mismatch_o;
                    cap_irq    = irq_o;
                end
                if (i == rst_cyc) begin
                    rst_ni = 1'b0;
                    #1;
                    checkResetValues("midreset");
                    last_h = 0; last_ha = 0; last_v = 0; last_va = 0;
                    m_cnt  = 0;
                    m_mm   = 1'b0;
                end
            end
        end
        clr_i      = 1'b0;
        mh[fidx]   = h;
        mha[fidx]  = ha;
        mv[fidx]   = v;
        mva[fidx]  = va;
        mcrc[fidx] = ~crc;
        fidx++;
    endtask

    task automatic checkLatch(input int k);
        m_stable = (mh[k] == last_h) && (mha[k] == last_ha) && (mv[k] == last_v) && (mva[k] == last_va);
        last_h  = mh[k];
        last_ha = mha[k];
        last_v  = mv[k];
        last_va = mva[k];
        m_cnt++;
        if (exp_valid_i && (mcrc[k] != exp_crc_i)) m_mm = 1'b1;
        checkOutput($sformatf("f%0d_pulses", k),    pulses, 1);
        checkOutput($sformatf("f%0d_htotal", k),    32'(cap_h), mh[k]);
        checkOutput($sformatf("f%0d_hactive", k),   32'(cap_ha), mha[k]);
        checkOutput($sformatf("f%0d_vtotal", k),    32'(cap_v), mv[k]);
        checkOutput($sformatf("f%0d_vactive", k),   32'(cap_va), mva[k]);
        checkOutput($sformatf("f%0d_crc", k),       cap_crc, mcrc[k]);
        checkOutput($sformatf("f%0d_frame_cnt", k), 32'(cap_cnt), m_cnt & 32'hFFFF);
        checkOutput($sformatf("f%0d_stable", k),    32'(cap_stable), 32'(m_stable));
        checkOutput($sformatf("f%0d_mismatch", k),  32'(cap_mm), 32'(m_mm));
        checkOutput($sformatf("f%0d_irq", k),       32'(cap_irq), 32'(m_mm));
    endtask

    initial begin
        $display("[TB] starting");
        #1 rst_ni = 1'b0;
        #1 checkResetValues("por");
        repeat (2) @(posedge dot_clk);
        #1;
        rst_ni = 1'b1;
        en_i   = 1'b1;
        repeat (3) @(posedge dot_clk);
        #1;

        applyStimulus(16, 10, 8, 5, 1'b0, -1, -1, -1);
        checkOutput("f0_first_edge_discarded", pulses, 0);
        applyStimulus(16, 10, 8, 5, 1'b0, -1, -1, -1);
        checkLatch(0);
        applyStimulus(16, 10, 8, 5, 1'b0, -1, -1, -1);
        checkLatch(1);
        checkOutput("second_latch_stable", 32'(cap_stable), 32'h1);

        applyStimulus(16, 1, 8, 1, 1'b1, -1, -1, -1);
        checkLatch(2);
        applyStimulus(16, 1, 8, 1, 1'b1, -1, -1, -1);
        checkLatch(3);
        checkOutput("single_zero_pixel_crc", cap_crc, 32'h2144_DF1C);

        exp_valid_i = 1'b1;
        exp_crc_i   = 32'h2144_DF1C;
        applyStimulus(16, 1, 8, 1, 1'b1, -1, -1, -1);
        checkLatch(4);

        exp_crc_i = 32'h0;
        applyStimulus(16, 10, 8, 5, 1'b0, 40, -1, -1);
        checkLatch(5);
        m_mm = 1'b0;
        checkOutput("mismatch_after_clr", 32'(mismatch_o), 32'h0);
        checkOutput("irq_after_clr", 32'(irq_o), 32'h0);

        applyStimulus(16, 10, 8, 5, 1'b0, 1, -1, -1);
        checkLatch(6);
        checkOutput("mismatch_set_wins", 32'(mismatch_o), 32'(m_mm));

        exp_valid_i = 1'b0;
        applyStimulus(16, 10, 8, 5, 1'b0, 40, -1, -1);
        checkLatch(7);
        m_mm = 1'b0;
        checkOutput("mismatch_cleared", 32'(mismatch_o), 32'h0);

        applyStimulus(18, 10, 8, 5, 1'b0, -1, -1, -1);
        checkLatch(8);
        applyStimulus(18, 10, 8, 5, 1'b0, -1, -1, -1);
        checkLatch(9);
        checkOutput("htotal_change_unstable", 32'(cap_stable), 32'h0);
        applyStimulus(18, 10, 8, 5, 1'b0, -1, -1, -1);
        checkLatch(10);
        checkOutput("htotal_change_restable", 32'(cap_stable), 32'h1);

        applyStimulus(18, 10, 8, 5, 1'b0, -1, 30, -1);
        checkLatch(11);
        checkOutput("en_off_stable_forced", 32'(stable_o), 32'h0);
        checkOutput("en_off_hold_htotal", 32'(htotal_o), 32'd18);
        checkOutput("en_off_hold_crc", crc_o, mcrc[11]);
        applyStimulus(18, 10, 8, 5, 1'b0, -1, -1, -1);
        checkOutput("reenable_no_pulse", pulses, 0);
        checkOutput("reenable_hold_crc", crc_o, mcrc[11]);
        checkOutput("reenable_hold_cnt", 32'(frame_cnt_o), m_cnt & 32'hFFFF);
        applyStimulus(18, 10, 8, 5, 1'b0, -1, -1, -1);
        checkLatch(13);

        applyStimulus(16, 10, 8, 5, 1'b0, -1, -1, -1);
        checkLatch(14);
        applyStimulus(16, 10, 8, 5, 1'b0, -1, -1, 50);
        applyStimulus(16, 10, 8, 5, 1'b0, -1, -1, -1);
        checkOutput("post_reset_no_pulse", pulses, 0);
        checkOutput("post_reset_cnt", 32'(frame_cnt_o), 32'h0);
        applyStimulus(16, 10, 8, 5, 1'b0, -1, -1, -1);
        checkLatch(17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_video_frame_signature.md
Name: rf_video_frame_signature

Overview:
Passive monitor that sits directly downstream of the frame buffer's video output (rgb, hsync, vsync, blank).
- Measures per-frame raster timing: htotal, hactive, vtotal, vactive.
- Computes a CRC-32 signature over all active pixels of each frame.
- Compares the signature against an expected value and raises an interrupt on mismatch.
- Used in benches and in silicon for self-test of the framebuffer → display path. Never drives or alters the video stream.

Parameters:
PIX_W, 32, pixel width in bits; must be a multiple of 8.
CTR_W, 12, width of all timing counters.
HSYNC_POL, 1'b0, active level of hsync_i.
VSYNC_POL, 1'b0, active level of vsync_i.

Ports:
dot_clk_i  in  1  pixel clock; all logic on its rising edge.
rst_ni  in  1  reset; asynchronous assert, active-low.
en_i  in  1  monitor enable.
rgb_i  in  PIX_W  pixel data from the frame buffer.
hsync_i  in  1  horizontal sync.
vsync_i  in  1  vertical sync.
blank_i  in  1  high = pixel not active.
exp_crc_i  in  32  expected frame CRC.
exp_valid_i  in  1  high = compare each frame against exp_crc_i.
clr_i  in  1  clears the sticky mismatch flag.
crc_o  out  32  CRC of the last complete frame.
htotal_o / hactive_o / vtotal_o / vactive_o  out  CTR_W each  timing of the last complete frame.
frame_cnt_o  out  16  count of completed frames; wraps.
meas_valid_o  out  1  one-cycle pulse when new results are latched.
stable_o  out  1  last two frames had identical timing.
mismatch_o  out  1  sticky CRC mismatch flag.
irq_o  out  1  equals mismatch_o.

Behaviour:
- Reset: all outputs 0, state IDLE, CRC accumulator 0xFFFFFFFF.
- Input stage: hsync_i, vsync_i, blank_i and rgb_i are registered once before use.
- Edge detection: an h-edge or v-edge is a registered-sync transition into its active level (per HSYNC_POL / VSYNC_POL).
- States:
  - IDLE: entered at reset or whenever en_i=0 (from any state, next cycle). Accumulators cleared; outputs hold their last values. Leaves to SYNC_WAIT when en_i=1.
  - SYNC_WAIT: discards the partial frame. Moves to MEASURE on the first v-edge; nothing is latched on that edge.
  - MEASURE: accumulates; on every v-edge, latches results and restarts the accumulators.
- Accumulators in MEASURE:
  - hcnt: increments every cycle. On an h-edge, it is copied to htotal_acc and reset to 1.
  - acnt: increments on each active cycle (blank=0). On an h-edge with acnt≠0, hactive_acc←acnt and lines_act increments; acnt is then reset to 0.
  - lines: increments on each h-edge.
  - All counters saturate at all-ones; they never wrap.
- CRC:
  - Reflected CRC-32: poly 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF.
  - Updated on every active cycle with PIX_W bits, byte 0 (rgb[7:0]) first, LSB first.
  - The full PIX_W-bit update completes in one cycle.
- Latch on v-edge:
  - Outputs take the values htotal_acc, hactive_acc, lines, lines_act and the finalised CRC.
  - frame_cnt_o increments.
  - meas_valid_o pulses. Latency is 2 cycles from the vsync_i transition at the input pins to meas_valid_o.
- Simultaneous h-edge and v-edge: the h-edge closes the last line of the ending frame (counted in that frame's vtotal). The new frame starts with lines=0 and hcnt=1.
- An active pixel coinciding with the v-edge belongs to the new frame.
- stable_o: on each latch, set to 1 if the new htotal/hactive/vtotal/vactive all equal the previous latched set, else 0. Forced to 0 in IDLE.
- Mismatch: at a latch with exp_valid_i=1 and finalised CRC ≠ exp_crc_i, mismatch_o←1. It stays set until clr_i. If set and clear occur in the same cycle, set wins.
- Reset asserted mid-frame: immediate return to reset values; the next frame after release is discarded via SYNC_WAIT.

Decomposition:
- Package rf_video_pkg holds:
  - constants CRC32_POLY_R, CRC32_INIT, CRC32_XOROUT;
  - struct video_timing_t {htotal, hactive, vtotal, vactive};
  - the sync-polarity enum.
- One sub-module, rf_crc32_update: purely combinational next-CRC over PIX_W bits. Instantiated once.

Test Plan:
- Raster htotal=16, hactive=10, vtotal=8, vactive=5, rgb=0, two frames → second meas_valid_o shows 16/10/8/5; stable_o=1; frame_cnt_o=2 (first v-edge discarded).
- One active pixel per frame with rgb=0x00000000 → crc_o=0x2144DF1C.
- Same raster with exp_crc_i=0x2144DF1C, exp_valid_i=1 → mismatch_o=0. Set exp_crc_i=0 → mismatch_o=1 and irq_o=1 after the next latch. Pulse clr_i → both 0. clr_i pulsed in the same cycle as a mismatching latch → mismatch_o stays 1.
- Change htotal 16→18 at a frame boundary → stable_o=0 on that latch and 1 on the following latch.
- Drop en_i mid-frame for 5 cycles → no meas_valid_o until a full frame after re-enable. Outputs hold their prior values meanwhile.
- Assert rst_ni mid-frame → all outputs 0 asynchronously. First frame after release is discarded.
